// File: rtl/rv_write_back.sv
// Write-back stage: registers memory-stage results, waits for load data, drives the register-file write port.
// Latency: non-load writes one cycle after capture; a load writes on the edge where its ack is seen.
// Backpressure: o_stall (combinational) freezes upstream while a load response is outstanding; timeout releases it.
module rv_write_back #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_alu_result,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic [1:0]  i_res_src,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_funct3,
  input  logic [29:0] i_pc_p4,
  input  logic [29:0] i_pc_target,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  output logic        o_stall,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_wdata,
  output logic        o_bus_err
);

  typedef struct packed {
    logic [31:0] alu_result;
    logic        reg_write;
    logic        mem_read;
    logic [1:0]  res_src;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [29:0] pc_p4;
    logic [29:0] pc_target;
  } wb_reg_t;

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  // Counter value on the last cycle a load may still be answered.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  wb_reg_t     wb_q;
  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        load_pending;
  logic        stall;
  logic        complete;
  logic        timeout;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] result;

  assign load_pending = wb_q.mem_read && (wb_q.res_src == 2'b01);
  assign o_stall      = stall;

  // WB register: take the memory-stage outputs whenever upstream is not frozen.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= '{alu_result: i_alu_result,
                reg_write:  i_reg_write,
                mem_read:   i_mem_read,
                res_src:    i_res_src,
                rd:         i_rd,
                funct3:     i_funct3,
                pc_p4:      i_pc_p4,
                pc_target:  i_pc_target};
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: decide whether the captured instruction completes, keeps waiting or times out.
  // On the timeout cycle the stall drops so the following instruction is captured at that edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!load_pending || i_dmem_ack) begin
          complete = 1'b1;
        end else begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (i_dmem_ack) begin
          complete = 1'b1;
          state_d  = ST_RUN;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Load alignment/extension and result source selection.
  always_comb begin
    load_byte = i_dmem_rdata[7:0];
    case (wb_q.alu_result[1:0])
      2'b00:   load_byte = i_dmem_rdata[7:0];
      2'b01:   load_byte = i_dmem_rdata[15:8];
      2'b10:   load_byte = i_dmem_rdata[23:16];
      default: load_byte = i_dmem_rdata[31:24];
    endcase
    load_half = wb_q.alu_result[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (wb_q.funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'b0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'b0, load_half};
      default: load_data = i_dmem_rdata;
    endcase
    case (wb_q.res_src)
      2'b00:   result = wb_q.alu_result;
      2'b01:   result = load_data;
      2'b10:   result = {wb_q.pc_p4, 2'b00};
      default: result = {wb_q.pc_target, 2'b00};
    endcase
  end

  // Register-file write port and bus-error pulse; rd/wdata hold unless an instruction completes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rf_we    <= 1'b0;
      o_rf_rd    <= '0;
      o_rf_wdata <= '0;
      o_bus_err  <= 1'b0;
    end else begin
      o_bus_err <= timeout;
      o_rf_we   <= complete && wb_q.reg_write && (wb_q.rd != 5'd0);
      if (complete) begin
        o_rf_rd    <= wb_q.rd;
        o_rf_wdata <= result;
      end
    end
  end

endmodule

// File: tb/tb_rv_write_back.sv
module tb_rv_write_back;

  localparam int TIMEOUT = 16;
  localparam int OBS_CYC = 22;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_alu_result;
  logic        i_reg_write;
  logic        i_mem_read;
  logic [1:0]  i_res_src;
  logic [4:0]  i_rd;
  logic [2:0]  i_funct3;
  logic [29:0] i_pc_p4;
  logic [29:0] i_pc_target;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_ack;
  logic        o_stall;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_wdata;
  logic        o_bus_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] alu;
    logic        reg_write;
    logic        mem_read;
    logic [1:0]  res_src;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [29:0] pc_p4;
    logic [29:0] pc_target;
    logic [31:0] rdata;
  } instr_t;

  rv_write_back #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_alu_result (i_alu_result),
    .i_reg_write  (i_reg_write),
    .i_mem_read   (i_mem_read),
    .i_res_src    (i_res_src),
    .i_rd         (i_rd),
    .i_funct3     (i_funct3),
    .i_pc_p4      (i_pc_p4),
    .i_pc_target  (i_pc_target),
    .i_dmem_rdata (i_dmem_rdata),
    .i_dmem_ack   (i_dmem_ack),
    .o_stall      (o_stall),
    .o_rf_we      (o_rf_we),
    .o_rf_rd      (o_rf_rd),
    .o_rf_wdata   (o_rf_wdata),
    .o_bus_err    (o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_result(input instr_t t);
    int          sh;
    int          v;
    logic [7:0]  b;
    logic [15:0] h;
    sh = 8 * int'(t.alu[1:0]);
    b  = 8'(t.rdata >> sh);
    h  = 16'(t.rdata >> (16 * int'(t.alu[1])));
    case (t.res_src)
      2'd0: return t.alu;
      2'd2: return 32'(t.pc_p4) * 4;
      2'd3: return 32'(t.pc_target) * 4;
      default: begin
        case (t.funct3)
          3'd0: begin v = $signed(b); return v; end
          3'd4: return 32'(b);
          3'd1: begin v = $signed(h); return v; end
          3'd5: return 32'(h);
          default: return t.rdata;
        endcase
      end
    endcase
  endfunction

  function automatic bit model_is_load(input instr_t t);
    return t.mem_read && (t.res_src == 2'd1);
  endfunction

  function automatic bit model_we(input instr_t t);
    return t.reg_write && (t.rd != 5'd0);
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.alu       = $urandom;
    t.reg_write = 1'($urandom_range(0, 3) != 0);
    t.res_src   = 2'($urandom_range(0, 3));
    t.mem_read  = (t.res_src == 2'd1) ? 1'b1 : 1'($urandom_range(0, 1));
    t.rd        = 5'($urandom_range(0, 31));
    t.funct3    = 3'($urandom_range(0, 7));
    t.pc_p4     = 30'($urandom);
    t.pc_target = 30'($urandom);
    t.rdata     = $urandom;
    return t;
  endfunction

  function automatic instr_t mk(input logic [31:0] alu, input logic rw, input logic mr,
                                input logic [1:0] rs, input logic [4:0] rd, input logic [2:0] f3,
                                input logic [29:0] p4, input logic [29:0] pt, input logic [31:0] rdat);
    instr_t t;
    t.alu = alu; t.reg_write = rw; t.mem_read = mr; t.res_src = rs; t.rd = rd;
    t.funct3 = f3; t.pc_p4 = p4; t.pc_target = pt; t.rdata = rdat;
    return t;
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic drive(input instr_t t);
    i_alu_result = t.alu;
    i_reg_write  = t.reg_write;
    i_mem_read   = t.mem_read;
    i_res_src    = t.res_src;
    i_rd         = t.rd;
    i_funct3     = t.funct3;
    i_pc_p4      = t.pc_p4;
    i_pc_target  = t.pc_target;
  endtask

  task automatic bubble();
    i_alu_result = '0;
    i_reg_write  = 1'b0;
    i_mem_read   = 1'b0;
    i_res_src    = '0;
    i_rd         = '0;
    i_funct3     = '0;
    i_pc_p4      = '0;
    i_pc_target  = '0;
  endtask

  // Present t for one edge, then bubbles; returns at the negedge starting t's first WB cycle.
  task automatic issue(input instr_t t);
    @(negedge i_clk);
    drive(t);
    i_dmem_ack = 1'b0;
    @(negedge i_clk);
    bubble();
    i_dmem_rdata = t.rdata;
  endtask

  // Runs ncyc WB cycles, pulsing ack on cycles ack_a/ack_b, and records what the DUT did.
  task automatic observe(input int ack_a, input int ack_b, input int ncyc,
                         output int stalls, output int writes, output int wr_cyc,
                         output int errs, output int err_cyc,
                         output logic [4:0] wr_rd, output logic [31:0] wr_data);
    stalls = 0; writes = 0; wr_cyc = -1; errs = 0; err_cyc = -1;
    wr_rd = '0; wr_data = '0;
    for (int k = 0; k < ncyc; k++) begin
      i_dmem_ack = (k == ack_a) || (k == ack_b);
      #1;
      if (o_stall === 1'b1) stalls++;
      @(negedge i_clk);
      i_dmem_ack = 1'b0;
      if (o_rf_we === 1'b1) begin
        writes++;
        if (wr_cyc < 0) begin wr_cyc = k; wr_rd = o_rf_rd; wr_data = o_rf_wdata; end
      end
      if (o_bus_err === 1'b1) begin
        errs++;
        if (err_cyc < 0) err_cyc = k;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_cmp++; if (o_rf_we !== 1'b0)     begin n_err++; $display("FAIL reset_we: got %0b want 0", o_rf_we); end
    n_cmp++; if (o_rf_rd !== 5'd0)     begin n_err++; $display("FAIL reset_rd: got %0d want 0", o_rf_rd); end
    n_cmp++; if (o_rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", o_rf_wdata); end
    n_cmp++; if (o_bus_err !== 1'b0)   begin n_err++; $display("FAIL reset_bus_err: got %0b want 0", o_bus_err); end
    n_cmp++; if (o_stall !== 1'b0)     begin n_err++; $display("FAIL reset_stall: got %0b want 0", o_stall); end
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_rf_we !== 1'b0)     begin n_err++; $display("FAIL post_reset_we: got %0b want 0", o_rf_we); end
  endtask

  task automatic test_alu();
    instr_t t;
    int st, wr, wc, er, ec;
    logic [4:0] rd;
    logic [31:0] wd;
    t = mk(32'h1234_5678, 1'b1, 1'b0, 2'd0, 5'd5, 3'd0, 30'd0, 30'd0, 32'd0);
    issue(t);
    observe(-1, -1, 4, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (st !== 0)               begin n_err++; $display("FAIL alu_stall: got %0d want 0", st); end
    n_cmp++; if (wr !== 1)               begin n_err++; $display("FAIL alu_writes: got %0d want 1", wr); end
    n_cmp++; if (wc !== 0)               begin n_err++; $display("FAIL alu_latency: got %0d want 0", wc); end
    n_cmp++; if (rd !== 5'd5)            begin n_err++; $display("FAIL alu_rd: got %0d want 5", rd); end
    n_cmp++; if (wd !== model_result(t)) begin n_err++; $display("FAIL alu_wdata: got %h want %h", wd, model_result(t)); end
  endtask

  task automatic test_byte_loads();
    instr_t t;
    int st, wr, wc, er, ec;
    logic [4:0] rd;
    logic [31:0] wd;
    logic [2:0] f3s [2];
    f3s[0] = 3'd0;
    f3s[1] = 3'd4;
    for (int i = 0; i < 2; i++) begin
      t = mk(32'h0000_1003, 1'b1, 1'b1, 2'd1, 5'd10, f3s[i], 30'd0, 30'd0, 32'h80FF_0000);
      issue(t);
      observe(0, -1, 4, st, wr, wc, er, ec, rd, wd);
      n_cmp++; if (st !== 0)               begin n_err++; $display("FAIL byte_stall f3=%0d: got %0d want 0", f3s[i], st); end
      n_cmp++; if (wr !== 1 || wc !== 0)   begin n_err++; $display("FAIL byte_write f3=%0d: got %0d@%0d want 1@0", f3s[i], wr, wc); end
      n_cmp++; if (wd !== model_result(t)) begin n_err++; $display("FAIL byte_wdata f3=%0d: got %h want %h", f3s[i], wd, model_result(t)); end
    end
  endtask

  task automatic test_lh_late();
    instr_t t;
    int st, wr, wc, er, ec;
    logic [4:0] rd;
    logic [31:0] wd;
    t = mk(32'h0000_2003, 1'b1, 1'b1, 2'd1, 5'd11, 3'd1, 30'd0, 30'd0, 32'h8001_ABCD);
    issue(t);
    observe(3, -1, 8, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (st !== 3)               begin n_err++; $display("FAIL lh_stall: got %0d want 3", st); end
    n_cmp++; if (wr !== 1)               begin n_err++; $display("FAIL lh_writes: got %0d want 1", wr); end
    n_cmp++; if (wc !== 3)               begin n_err++; $display("FAIL lh_latency: got %0d want 3", wc); end
    n_cmp++; if (wd !== model_result(t)) begin n_err++; $display("FAIL lh_wdata: got %h want %h", wd, model_result(t)); end
    n_cmp++; if (er !== 0)               begin n_err++; $display("FAIL lh_bus_err: got %0d want 0", er); end
  endtask

  task automatic test_pc_x0();
    instr_t t;
    int st, wr, wc, er, ec;
    logic [4:0] rd;
    logic [31:0] wd;
    t = mk(32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2, 5'd7, 3'd0, 30'h0000_0401, 30'd0, 32'd0);
    issue(t);
    observe(-1, -1, 4, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (wr !== 1)               begin n_err++; $display("FAIL pc4_writes: got %0d want 1", wr); end
    n_cmp++; if (wd !== model_result(t)) begin n_err++; $display("FAIL pc4_wdata: got %h want %h", wd, model_result(t)); end
    t.rd = 5'd0;
    issue(t);
    observe(-1, -1, 4, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (wr !== 0)               begin n_err++; $display("FAIL x0_writes: got %0d want 0", wr); end
    t = mk(32'd0, 1'b1, 1'b0, 2'd3, 5'd31, 3'd0, 30'd0, 30'($urandom), 32'd0);
    issue(t);
    observe(-1, -1, 4, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (wd !== model_result(t)) begin n_err++; $display("FAIL pct_wdata: got %h want %h", wd, model_result(t)); end
  endtask

  task automatic test_timeout();
    instr_t t;
    int st, wr, wc, er, ec;
    logic [4:0] rd;
    logic [31:0] wd;
    t = mk(32'h0000_0100, 1'b1, 1'b1, 2'd1, 5'd9, 3'd2, 30'd0, 30'd0, 32'hCAFE_F00D);
    issue(t);
    observe(TIMEOUT + 2, -1, OBS_CYC, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (st !== TIMEOUT - 1) begin n_err++; $display("FAIL to_stall: got %0d want %0d", st, TIMEOUT - 1); end
    n_cmp++; if (er !== 1)           begin n_err++; $display("FAIL to_err_count: got %0d want 1", er); end
    n_cmp++; if (ec !== TIMEOUT - 1) begin n_err++; $display("FAIL to_err_cycle: got %0d want %0d", ec, TIMEOUT - 1); end
    n_cmp++; if (wr !== 0)           begin n_err++; $display("FAIL to_writes: got %0d want 0", wr); end
    t = mk($urandom, 1'b1, 1'b0, 2'd0, 5'd20, 3'd0, 30'd0, 30'd0, 32'd0);
    issue(t);
    observe(-1, -1, 4, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (wr !== 1 || wc !== 0 || st !== 0) begin n_err++; $display("FAIL to_next: got writes=%0d@%0d stalls=%0d want 1@0 stalls=0", wr, wc, st); end
    n_cmp++; if (wd !== model_result(t))           begin n_err++; $display("FAIL to_next_wdata: got %h want %h", wd, model_result(t)); end
  endtask

  task automatic test_random();
    instr_t t;
    int st, wr, wc, er, ec;
    int d, b, e_st, e_wr, e_er;
    logic [4:0] rd;
    logic [31:0] wd;
    for (int i = 0; i < 40; i++) begin
      t = rand_instr();
      if (model_is_load(t)) begin
        d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
        b = (d < 0) ? $urandom_range(TIMEOUT, OBS_CYC - 1) : $urandom_range(d + 1, OBS_CYC - 1);
      end else begin
        d = -1;
        b = $urandom_range(0, OBS_CYC - 1);
      end
      e_st = !model_is_load(t) ? 0 : (d >= 0 ? d : TIMEOUT - 1);
      e_er = (model_is_load(t) && d < 0) ? 1 : 0;
      e_wr = (e_er == 0 && model_we(t)) ? 1 : 0;
      issue(t);
      observe(d, b, OBS_CYC, st, wr, wc, er, ec, rd, wd);
      n_cmp++; if (st !== e_st) begin n_err++; $display("FAIL rnd%0d_stall: got %0d want %0d", i, st, e_st); end
      n_cmp++; if (wr !== e_wr) begin n_err++; $display("FAIL rnd%0d_writes: got %0d want %0d", i, wr, e_wr); end
      n_cmp++; if (er !== e_er) begin n_err++; $display("FAIL rnd%0d_bus_err: got %0d want %0d", i, er, e_er); end
      if (e_wr == 1) begin
        n_cmp++; if (wc !== e_st)            begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, wc, e_st); end
        n_cmp++; if (rd !== t.rd)            begin n_err++; $display("FAIL rnd%0d_rd: got %0d want %0d", i, rd, t.rd); end
        n_cmp++; if (wd !== model_result(t)) begin n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", i, wd, model_result(t)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    instr_t q[$];
    instr_t t;
    for (int i = 0; i < 14; i++) begin
      @(negedge i_clk);
      if (i >= 2) begin
        t = q[i - 2];
        n_cmp++; if (o_rf_we !== model_we(t))        begin n_err++; $display("FAIL b2b%0d_we: got %0b want %0b", i, o_rf_we, model_we(t)); end
        n_cmp++; if (o_rf_rd !== t.rd)               begin n_err++; $display("FAIL b2b%0d_rd: got %0d want %0d", i, o_rf_rd, t.rd); end
        n_cmp++; if (o_rf_wdata !== model_result(t)) begin n_err++; $display("FAIL b2b%0d_wdata: got %h want %h", i, o_rf_wdata, model_result(t)); end
      end
      if (i < 12) begin
        t = rand_instr();
        q.push_back(t);
        drive(t);
      end else begin
        bubble();
      end
      if (i >= 1 && i - 1 < q.size()) i_dmem_rdata = q[i - 1].rdata;
      i_dmem_ack = 1'b1;
      #1;
      n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL b2b%0d_stall: got %0b want 0", i, o_stall); end
    end
    i_dmem_ack = 1'b0;
  endtask

  task automatic test_reset_wait();
    instr_t t;
    int st, wr, wc, er, ec;
    logic [4:0] rd;
    logic [31:0] wd;
    t = mk(32'h0F0F_0F0F, 1'b1, 1'b0, 2'd0, 5'd12, 3'd0, 30'd0, 30'd0, 32'd0);
    issue(t);
    observe(-1, -1, 2, st, wr, wc, er, ec, rd, wd);
    t = mk(32'h0000_0040, 1'b1, 1'b1, 2'd1, 5'd3, 3'd2, 30'd0, 30'd0, 32'h1357_9BDF);
    issue(t);
    repeat (3) @(negedge i_clk);
    #1;
    n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL rstw_pre_stall: got %0b want 1", o_stall); end
    #1;
    i_reset = 1'b1;
    #1;
    n_cmp++; if (o_rf_we !== 1'b0)     begin n_err++; $display("FAIL rstw_we: got %0b want 0", o_rf_we); end
    n_cmp++; if (o_rf_rd !== 5'd0)     begin n_err++; $display("FAIL rstw_rd: got %0d want 0", o_rf_rd); end
    n_cmp++; if (o_rf_wdata !== 32'd0) begin n_err++; $display("FAIL rstw_wdata: got %h want 0", o_rf_wdata); end
    n_cmp++; if (o_bus_err !== 1'b0)   begin n_err++; $display("FAIL rstw_bus_err: got %0b want 0", o_bus_err); end
    n_cmp++; if (o_stall !== 1'b0)     begin n_err++; $display("FAIL rstw_stall: got %0b want 0", o_stall); end
    bubble();
    @(negedge i_clk);
    i_reset = 1'b0;
    observe(1, 4, OBS_CYC, st, wr, wc, er, ec, rd, wd);
    n_cmp++; if (wr !== 0) begin n_err++; $display("FAIL rstw_writes: got %0d want 0", wr); end
    n_cmp++; if (er !== 0) begin n_err++; $display("FAIL rstw_late_err: got %0d want 0", er); end
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL rstw_late_stall: got %0d want 0", st); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset      = 1'b1;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = '0;
    bubble();
    test_reset();
    test_alu();
    test_byte_loads();
    test_lh_late();
    test_pc_x0();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
